// File: rtl/conv_matrix_engine_pkg.sv
// Shared types and helpers for the binary convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD,
    FULL,
    CONV,
    DONE
  } conv_state_t;

  // Width that holds a popcount of 0..ksize*ksize exactly.
  function automatic int popcount_w(input int ksize);
    return $clog2(ksize * ksize + 1);
  endfunction

endpackage

// File: rtl/conv_matrix_engine_if.sv
// Result stream of the convolution engine: valid/ready plus data and position.
interface conv_matrix_engine_if
  import conv_pkg::*;
#(
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int KSIZE = 3
);
  localparam int OUT_W = popcount_w(KSIZE);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  modport master (output out_valid, out_data, out_row, out_col, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col, output out_ready);
endinterface

// File: rtl/conv_matrix_engine_window_popcount.sv
// Combinational window extract + popcount at position (r_i, c_i).
// CONV_XNOR_EN selects XNOR similarity instead of AND.
module conv_window_popcount
  import conv_pkg::*;
#(
  parameter  int IMG_W = 6,
  parameter  int IMG_H = 6,
  parameter  int KSIZE = 3,
  localparam int OUT_W = popcount_w(KSIZE),
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic [IMG_H-1:0][IMG_W-1:0] image_i,
  input  logic [ROW_W-1:0]            r_i,
  input  logic [COL_W-1:0]            c_i,
  input  logic [KSIZE*KSIZE-1:0]      kernel_i,
  output logic [OUT_W-1:0]            count_o
);

  logic [ROW_W-1:0] ri;
  logic [COL_W-1:0] ci;
  logic             pix;
  logic             wt;

  always_comb begin
    count_o = '0;
    ri      = '0;
    ci      = '0;
    pix     = 1'b0;
    wt      = 1'b0;
    for (int i = 0; i < KSIZE; i++) begin
      ri = r_i + ROW_W'(i);
      for (int j = 0; j < KSIZE; j++) begin
        ci  = c_i + COL_W'(j);
        pix = image_i[ri][ci];
        wt  = kernel_i[i*KSIZE+j];
`ifdef CONV_XNOR_EN
        count_o = count_o + OUT_W'(~(pix ^ wt));
`else
        count_o = count_o + OUT_W'(pix & wt);
`endif
      end
    end
  end

endmodule

// File: rtl/conv_matrix_engine.sv
// Binary image convolution engine: row loader, FSM, raster position counters.
// Build with CONV_XNOR_EN defined for XNOR-popcount results.
module conv_matrix_engine
  import conv_pkg::*;
#(
  parameter  int IMG_W = 6,
  parameter  int IMG_H = 6,
  parameter  int KSIZE = 3,
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int CNT_W = $clog2(IMG_H + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IMG_W-1:0]       row_data,
  input  logic                   row_strobe,
  input  logic [KSIZE*KSIZE-1:0] kernel,
  input  logic                   start,
  input  logic                   clear,
  conv_matrix_engine_if.master   out_if,
  output logic [CNT_W-1:0]       row_count,
  output logic                   busy,
  output logic                   done
);

  localparam int OUT_W = popcount_w(KSIZE);
  localparam logic [ROW_W-1:0] R_LAST  = ROW_W'(IMG_H - KSIZE);
  localparam logic [COL_W-1:0] C_LAST  = COL_W'(IMG_W - KSIZE);
  localparam logic [CNT_W-1:0] ROW_FIN = CNT_W'(IMG_H - 1);

  conv_state_t                 state_q, state_d;
  logic [CNT_W-1:0]            row_count_q, row_count_d;
  logic [ROW_W-1:0]            r_q, r_d;
  logic [COL_W-1:0]            c_q, c_d;
  logic [KSIZE*KSIZE-1:0]      kernel_q, kernel_d;
  logic                        strobe_q;
  logic                        strobe_edge;
  logic                        img_we;
  logic [IMG_H-1:0][IMG_W-1:0] image_q;
  logic [OUT_W-1:0]            pc_count;

  assign strobe_edge = row_strobe & ~strobe_q;

  always_comb begin
    // NOTE: every target gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    row_count_d = row_count_q;
    r_d         = r_q;
    c_d         = c_q;
    kernel_d    = kernel_q;
    img_we      = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (strobe_edge) begin
          img_we      = 1'b1;
          row_count_d = row_count_q + CNT_W'(1);
          if (row_count_q == ROW_FIN) state_d = FULL;
        end
      end
      FULL: begin
        if (start) begin
          kernel_d = kernel;
          r_d      = '0;
          c_d      = '0;
          state_d  = CONV;
        end
      end
      CONV: begin
        if (out_if.out_ready) begin
          if (c_q == C_LAST) begin
            c_d = '0;
            if (r_q == R_LAST) begin
              r_d     = '0;
              state_d = DONE;
            end else begin
              r_d = r_q + ROW_W'(1);
            end
          end else begin
            c_d = c_q + COL_W'(1);
          end
        end
      end
      DONE: begin
        state_d     = LOAD;
        row_count_d = '0;
      end
      default: state_d = LOAD;
    endcase
    // Abort has priority over start and strobe edges in the same cycle.
    if (clear) begin
      state_d     = LOAD;
      row_count_d = '0;
      r_d         = '0;
      c_d         = '0;
      img_we      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      row_count_q <= '0;
      r_q         <= '0;
      c_q         <= '0;
      kernel_q    <= '0;
      strobe_q    <= 1'b0;
      // NOTE: the image is architecturally cleared by reset, so this storage is reset unlike a plain RAM.
      image_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      row_count_q <= row_count_d;
      r_q         <= r_d;
      c_q         <= c_d;
      kernel_q    <= kernel_d;
      strobe_q    <= row_strobe;
      if (img_we) image_q[row_count_q[ROW_W-1:0]] <= row_data;
    end
  end

  conv_window_popcount #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .KSIZE (KSIZE)
  ) u_window (
    .image_i  (image_q),
    .r_i      (r_q),
    .c_i      (c_q),
    .kernel_i (kernel_q),
    .count_o  (pc_count)
  );

  // Result is a pure function of registered state, so it is stable during back-pressure.
  assign out_if.out_valid = (state_q == CONV);
  assign out_if.out_data  = (state_q == CONV) ? pc_count : '0;
  assign out_if.out_row   = r_q;
  assign out_if.out_col   = c_q;
  assign row_count        = row_count_q;
  assign busy             = (state_q == CONV);
  assign done             = (state_q == DONE);

endmodule

// File: tb/tb_conv_matrix_engine.sv
// Directed self-checking bench for conv_matrix_engine (default 6x6 image, 3x3 kernel).
module tb_conv_matrix_engine;

  logic       clk;
  logic       rst;
  logic [5:0] row_data;
  logic       row_strobe;
  logic [8:0] kernel;
  logic       start;
  logic       clear;
  logic [2:0] row_count;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  conv_matrix_engine_if #(.IMG_W(6), .IMG_H(6), .KSIZE(3)) out_if ();

  conv_matrix_engine dut (
    .clk        (clk),
    .rst        (rst),
    .row_data   (row_data),
    .row_strobe (row_strobe),
    .kernel     (kernel),
    .start      (start),
    .clear      (clear),
    .out_if     (out_if),
    .row_count  (row_count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [5:0] d);
    row_data   = d;
    row_strobe = 1'b1;
    step(1);
    row_strobe = 1'b0;
    step(1);
  endtask

  // Expected result on the identity image (pixel set where row == column).
  function automatic int exp_ident(input int r, input int c, input logic [8:0] k);
    int n = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        logic p;
        p = ((r + i) == (c + j));
`ifdef CONV_XNOR_EN
        n += (p == k[i*3+j]) ? 1 : 0;
`else
        n += (p && k[i*3+j]) ? 1 : 0;
`endif
      end
    return n;
  endfunction

  initial begin
    rst        = 1'b1;
    row_data   = '0;
    row_strobe = 1'b0;
    kernel     = '0;
    start      = 1'b0;
    clear      = 1'b0;
    out_if.out_ready = 1'b0;

    #2;
    check("reset valid", 32'(out_if.out_valid), 0);
    check("reset data", 32'(out_if.out_data), 0);
    check("reset row_count", 32'(row_count), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    step(2);
    rst = 1'b0;

    // Held strobe loads exactly one row.
    row_data   = 6'h3F;
    row_strobe = 1'b1;
    step(10);
    check("held strobe row_count", 32'(row_count), 1);
    row_strobe = 1'b0;
    step(1);
    for (int k = 0; k < 5; k++) load_row(6'h3F);
    check("full row_count", 32'(row_count), 6);
    load_row(6'h00);
    check("7th strobe in FULL", 32'(row_count), 6);
    check("FULL not busy", 32'(busy), 0);

    // All-ones image, all-ones kernel: 16 results of 9 in raster order.
    kernel = 9'h1FF;
    out_if.out_ready = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ones p%0d valid", k), 32'(out_if.out_valid), 1);
      check($sformatf("ones p%0d data", k), 32'(out_if.out_data), 9);
      check($sformatf("ones p%0d row", k), 32'(out_if.out_row), 32'(k / 4));
      check($sformatf("ones p%0d col", k), 32'(out_if.out_col), 32'(k % 4));
      step(1);
    end
    check("ones done pulse", 32'(done), 1);
    check("ones done valid", 32'(out_if.out_valid), 0);
    step(1);
    check("ones done low", 32'(done), 0);
    check("ones back to LOAD", 32'(row_count), 0);

    start = 1'b1;
    step(1);
    start = 1'b0;
    check("start in LOAD ignored", 32'(busy), 0);

    // Identity image, centre-only kernel; kernel input changes mid-run.
    for (int k = 0; k < 6; k++) load_row(6'(1 << k));
    kernel = 9'h010;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) kernel = 9'h1FF;
      check($sformatf("ident p%0d data", k), 32'(out_if.out_data), 32'(exp_ident(k / 4, k % 4, 9'h010)));
      step(1);
    end
    check("ident done", 32'(done), 1);
    step(1);

    // Back-pressure at (1,2).
    for (int k = 0; k < 6; k++) load_row(6'h3F);
    kernel = 9'h0F5;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
    step(6);
    check("stall start row", 32'(out_if.out_row), 1);
    check("stall start col", 32'(out_if.out_col), 2);
    out_if.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check($sformatf("stall c%0d valid", k), 32'(out_if.out_valid), 1);
      check($sformatf("stall c%0d row", k), 32'(out_if.out_row), 1);
      check($sformatf("stall c%0d col", k), 32'(out_if.out_col), 2);
      check($sformatf("stall c%0d data", k), 32'(out_if.out_data), 6);
    end
    out_if.out_ready = 1'b1;
    step(1);
    check("release row", 32'(out_if.out_row), 1);
    check("release col", 32'(out_if.out_col), 3);

    // Clear after three more handshakes.
    step(3);
    check("pre-clear col", 32'(out_if.out_col), 2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear valid", 32'(out_if.out_valid), 0);
    check("clear busy", 32'(busy), 0);
    check("clear row_count", 32'(row_count), 0);
    check("clear done", 32'(done), 0);

    // Clear beats start, and beats a strobe edge.
    for (int k = 0; k < 6; k++) load_row(6'h3F);
    clear = 1'b1;
    start = 1'b1;
    step(1);
    clear = 1'b0;
    start = 1'b0;
    check("clear+start busy", 32'(busy), 0);
    check("clear+start row_count", 32'(row_count), 0);
    row_strobe = 1'b1;
    clear      = 1'b1;
    step(1);
    clear      = 1'b0;
    row_strobe = 1'b0;
    check("clear+strobe row_count", 32'(row_count), 0);
    step(1);

    // Asynchronous reset in the middle of CONV.
    for (int k = 0; k < 6; k++) load_row(6'h3F);
    kernel = 9'h1FF;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
    step(2);
    check("pre-rst busy", 32'(busy), 1);
    check("pre-rst col", 32'(out_if.out_col), 2);
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", 32'(out_if.out_valid), 0);
    check("async rst data", 32'(out_if.out_data), 0);
    check("async rst col", 32'(out_if.out_col), 0);
    check("async rst row_count", 32'(row_count), 0);
    check("async rst busy", 32'(busy), 0);
    step(1);
    rst = 1'b0;

    // All-zero image with zero kernel, then all-ones kernel.
    for (int k = 0; k < 6; k++) load_row(6'h00);
    kernel = 9'h000;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
    for (int k = 0; k < 16; k++) begin
`ifdef CONV_XNOR_EN
      check($sformatf("zero k0 p%0d data", k), 32'(out_if.out_data), 9);
`else
      check($sformatf("zero k0 p%0d data", k), 32'(out_if.out_data), 0);
`endif
      step(1);
    end
    check("zero k0 done", 32'(done), 1);
    step(1);
    for (int k = 0; k < 6; k++) load_row(6'h00);
    kernel = 9'h1FF;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("zero k1 p%0d valid", k), 32'(out_if.out_valid), 1);
      check($sformatf("zero k1 p%0d data", k), 32'(out_if.out_data), 0);
      step(1);
    end
    check("zero k1 done", 32'(done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
